// File: rtl/i3c_bus_monitor.sv
// I3C bus monitor front end: synchronizes and debounces raw SCL/SDA, detects SCL
// edges and START/Repeated START/STOP, and assembles bytes plus the 9th (T/ACK) bit.
module i3c_bus_monitor #(
  parameter int SyncStages = 2,
  parameter int FilterW    = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic               scl_i,
  input  logic               sda_i,
  input  logic [FilterW-1:0] filt_cycles_i,
  output logic               scl_o,
  output logic               sda_o,
  output logic               scl_posedge_o,
  output logic               scl_negedge_o,
  output logic               start_det_o,
  output logic               rstart_det_o,
  output logic               stop_det_o,
  output logic               bus_busy_o,
  output logic [7:0]         rx_byte_o,
  output logic               rx_byte_valid_o,
  output logic               rx_tbit_o,
  output logic               rx_tbit_valid_o
);

  logic [SyncStages-1:0]     scl_sync_q, sda_sync_q;
  logic [1:0]                sync_s;          // bit 0 = SCL, bit 1 = SDA
  logic [1:0]                f_q, f_d, p_q;
  logic [1:0][FilterW-1:0]   cnt_q, cnt_d;
  logic                      scl_rise_s, scl_fall_s, start_s, stop_s;
  logic                      busy_q, busy_d;
  logic [3:0]                bcnt_q, bcnt_d;
  logic [6:0]                shift_q, shift_d;
  logic [7:0]                byte_q, byte_d;
  logic                      tbit_q, tbit_d;
  logic                      start_q, start_d, rstart_q, rstart_d, stop_q, stop_d;
  logic                      bv_q, bv_d, tv_q, tv_d;
  logic                      pos_q, neg_q;

  assign sync_s = {sda_sync_q[SyncStages-1], scl_sync_q[SyncStages-1]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SyncStages-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SyncStages-2:0], sda_i};
    end
  end

  // A line only follows the synchronized input after N+1 consecutive differing samples.
  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync_s[i] == f_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == filt_cycles_i) begin
        f_d[i]   = sync_s[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Conditions need SCL high in both cycles, so a simultaneous SCL change masks them.
  assign scl_rise_s = ~p_q[0] &  f_q[0];
  assign scl_fall_s =  p_q[0] & ~f_q[0];
  assign start_s    =  p_q[1] & ~f_q[1] & p_q[0] & f_q[0];
  assign stop_s     = ~p_q[1] &  f_q[1] & p_q[0] & f_q[0];

  always_comb begin
    busy_d   = busy_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    tbit_d   = tbit_q;
    start_d  = 1'b0;
    rstart_d = 1'b0;
    stop_d   = 1'b0;
    bv_d     = 1'b0;
    tv_d     = 1'b0;
    if (!enable_i) begin
      busy_d = 1'b0;
      bcnt_d = 4'd0;
    end else if (start_s) begin
      busy_d   = 1'b1;
      bcnt_d   = 4'd0;
      start_d  = ~busy_q;
      rstart_d = busy_q;
    end else if (stop_s) begin
      busy_d = 1'b0;
      bcnt_d = 4'd0;
      stop_d = 1'b1;
    end else if (scl_rise_s && busy_q) begin
      if (bcnt_q == 4'd8) begin
        tbit_d = f_q[1];
        tv_d   = 1'b1;
        bcnt_d = 4'd0;
      end else begin
        shift_d = {shift_q[5:0], f_q[1]};
        bcnt_d  = bcnt_q + 4'd1;
        if (bcnt_q == 4'd7) begin
          byte_d = {shift_q, f_q[1]};
          bv_d   = 1'b1;
        end else begin
          bv_d = 1'b0;
        end
      end
    end else begin
      busy_d = busy_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      f_q      <= 2'b11;
      p_q      <= 2'b11;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      bcnt_q   <= 4'd0;
      shift_q  <= 7'd0;
      byte_q   <= 8'd0;
      tbit_q   <= 1'b0;
      start_q  <= 1'b0;
      rstart_q <= 1'b0;
      stop_q   <= 1'b0;
      bv_q     <= 1'b0;
      tv_q     <= 1'b0;
      pos_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      f_q      <= f_d;
      p_q      <= f_q;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      tbit_q   <= tbit_d;
      start_q  <= start_d;
      rstart_q <= rstart_d;
      stop_q   <= stop_d;
      bv_q     <= bv_d;
      tv_q     <= tv_d;
      pos_q    <= scl_rise_s;
      neg_q    <= scl_fall_s;
    end
  end

  assign scl_o           = f_q[0];
  assign sda_o           = f_q[1];
  assign scl_posedge_o   = pos_q;
  assign scl_negedge_o   = neg_q;
  assign start_det_o     = start_q;
  assign rstart_det_o    = rstart_q;
  assign stop_det_o      = stop_q;
  assign bus_busy_o      = busy_q;
  assign rx_byte_o       = byte_q;
  assign rx_byte_valid_o = bv_q;
  assign rx_tbit_o       = tbit_q;
  assign rx_tbit_valid_o = tv_q;

endmodule

// File: doc/i3c_bus_monitor.md
# i3c_bus_monitor

Front-end receive stage between the I3C pad cell (`i3c_io`) and the controller/target PHY inside `i3c`. It synchronizes and glitch-filters the raw SCL/SDA pad inputs, and detects SCL edges and START, Repeated START and STOP conditions. It also assembles serial bits into bytes plus the 9th (T/ACK) bit. All outputs are registered single-cycle strobes or levels in the `clk_i` domain.

## Interface
Parameters:
- `SyncStages`, 2: number of synchronizer flops per line; legal values ≥2.
- `FilterW`, 4: width of the filter counter and of `filt_cycles_i`.

Ports:
- `clk_i` in 1: the single clock for the block.
- `rst_ni` in 1: reset, synchronous and active-low.
- `enable_i` in 1: enables condition detection and byte assembly.
- `scl_i` in 1: raw SCL from the pad, asynchronous.
- `sda_i` in 1: raw SDA from the pad, asynchronous.
- `filt_cycles_i` in FilterW: debounce length N; treated as quasi-static.
- `scl_o` out 1: filtered SCL.
- `sda_o` out 1: filtered SDA.
- `scl_posedge_o` out 1: one-cycle strobe on a filtered SCL rise.
- `scl_negedge_o` out 1: one-cycle strobe on a filtered SCL fall.
- `start_det_o` out 1: START strobe.
- `rstart_det_o` out 1: Repeated START strobe.
- `stop_det_o` out 1: STOP strobe.
- `bus_busy_o` out 1: level, high from START until STOP.
- `rx_byte_o` out 8: last assembled byte, MSB first.
- `rx_byte_valid_o` out 1: one-cycle strobe; `rx_byte_o` is updated in the same cycle.
- `rx_tbit_o` out 1: value of the 9th bit.
- `rx_tbit_valid_o` out 1: one-cycle strobe for the 9th bit.

## Operation
- **Synchronizer:** each line passes through `SyncStages` flops. All flops reset to 1 (idle bus).
- **Filter, per line:**
  - Register `f` (drives `scl_o` / `sda_o`) and counter `cnt`.
  - If the synced value equals `f`, then `cnt <= 0`.
  - Otherwise, if `cnt == filt_cycles_i`, then `f <=` synced value and `cnt <= 0`.
  - Otherwise, `cnt <= cnt + 1`.
  - A change therefore needs N+1 consecutive differing cycles to propagate.
  - N=0 means no filtering; only one register stage is added.
  - `cnt` saturates logically at N and never wraps.
- **Edge/condition detection:** uses `f` and its one-cycle-delayed copy `p`.
  - SCL posedge = `p_scl=0 & f_scl=1`; SCL negedge is the inverse.
  - START = `p_sda=1 & f_sda=0 & p_scl=1 & f_scl=1`. It is reported on `rstart_det_o` if `bus_busy_o=1`, otherwise on `start_det_o`.
  - STOP = `p_sda=0 & f_sda=1 & p_scl=1 & f_scl=1`.
  - If SCL and SDA change in the same cycle, no condition is detected.
  - A STOP while `bus_busy_o=0` still pulses `stop_det_o`.
- **`bus_busy_o`:** set on START or Repeated START, cleared on STOP.
- **Bit counter `bcnt` (0..8):**
  - Cleared on START, Repeated START and STOP.
  - On each SCL posedge while busy, `sda_f` is sampled.
  - For `bcnt` 0..7, the sample shifts into a shift register (MSB first). On `bcnt==7` the full byte loads `rx_byte_o` and `rx_byte_valid_o` pulses.
  - For `bcnt==8`, the sample loads `rx_tbit_o`, `rx_tbit_valid_o` pulses, and `bcnt` wraps to 0.
  - If a START/STOP and an SCL posedge occur in the same cycle, the condition wins and no bit is sampled.
- **`enable_i=0`:** the synchronizer, filter, `scl_o`/`sda_o` and the edge strobes keep running. All condition strobes, `rx_*_valid_o` and `bus_busy_o` are forced to 0, and `bcnt` is cleared. `rx_byte_o` and `rx_tbit_o` hold their values.
- **Reset values:** `scl_o=1`, `sda_o=1`, all strobes 0, `bus_busy_o=0`, `rx_byte_o=0x00`, `rx_tbit_o=0`. Internal `p` registers = 1, `cnt=0`, `bcnt=0`, shift register 0.
- **Reset mid-transfer:** the partial byte is discarded. After reset the bus is considered idle, so the next START reports on `start_det_o`, not `rstart_det_o`.

## Timing
- **Pad to `scl_o`/`sda_o`:** `SyncStages + N + 1` cycles after the pad level settles (stable input assumed).
- **Filtered change to strobes:** all strobes and the `bus_busy_o` change assert 1 cycle after the corresponding `f` transition becomes visible on `scl_o`/`sda_o`.
- **Byte delivery:** `rx_byte_o` and `rx_byte_valid_o` update in the same cycle as the 8th `scl_posedge_o` strobe.
- **Pulse width:** every strobe is exactly 1 cycle. Back-to-back strobes of the same kind are not possible for `filt_cycles_i ≥ 0`, because each needs an opposite transition in between.
- **Glitch rejection:** a glitch shorter than N+1 cycles after synchronization produces no output activity.
- **`filt_cycles_i`:** changes take effect on the next comparison; there is no reset of `cnt`.

## Test plan
- **Reset and idle:** hold `rst_ni=0` 3 cycles with `scl_i=sda_i=0`, then release with both at 1 → all outputs at reset values, no strobes for 20 cycles.
- **Glitch filter:** N=3; apply a 3-cycle SDA low pulse while SCL=1 → no `start_det_o`. Apply a 4-cycle low pulse → `sda_o` falls exactly `SyncStages+4` cycles after the pad edge, and `start_det_o` pulses 1 cycle later.
- **Byte receive:** N=0; START, then 0xA5 MSB first, 9th bit 0, then STOP → `start_det_o` once; `rx_byte_o=0xA5` with one `rx_byte_valid_o`; `rx_tbit_o=0` with `rx_tbit_valid_o`; `stop_det_o` once; `bus_busy_o` high between START and STOP.
- **Repeated START:** START, 4 bits, then a Repeated START, then 0x3C → `rstart_det_o` (not `start_det_o`) pulses; the partial byte is dropped; `rx_byte_o=0x3C`.
- **Simultaneous edges:** drive SCL fall and SDA fall in the same filtered cycle → `scl_negedge_o` only, no START.
- **`enable_i` and mid-byte reset:** deassert `enable_i` mid-byte → `bus_busy_o=0` next cycle and no `rx_byte_valid_o`. Separately, pulse `rst_ni` low for 1 cycle mid-byte, then send a START → `start_det_o`, not `rstart_det_o`.
